// File: rtl/vga_pkg.sv
// Shared VGA raster constants, RGB565 colours, fetch FSM state type and a span helper.
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  typedef enum logic {
    WAIT_FRAME,
    RUN
  } fetch_state_t;

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous active-high clear.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_window_fetch.sv
// Maps raster position onto a linear ROM address for a windowed RGB565 image and
// realigns syncs/DE with ROM data. Optional white frame: define VGA_WINDOW_BORDER_EN.
module vga_window_fetch
  import vga_pkg::*;
#(
  parameter int          IMG_W    = 200,
  parameter int          IMG_H    = 160,
  parameter int          X0       = 300,
  parameter int          Y0       = 220,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter int          ROM_LAT  = 1
) (
  input  logic           CLK_40M,
  input  logic           RST,
  input  logic           DE_IN,
  input  logic           HSYNC_IN,
  input  logic           VSYNC_IN,
  input  logic [X_W-1:0] X_IN,
  input  logic [Y_W-1:0] Y_IN,
  output logic [15:0]    ROM_ADDR,
  input  logic [15:0]    ROM_Q,
  output logic           HSYNC_OUT,
  output logic           VSYNC_OUT,
  output logic           DE_OUT,
  output logic [15:0]    DATA_OUT
);
  localparam int unsigned L = 1 + ROM_LAT;
  // Window is clamped to the visible raster even if misparameterised.
  localparam int X_LAST = (X0 + IMG_W <= H_ACTIVE) ? X0 + IMG_W - 1 : H_ACTIVE - 1;
  localparam int Y_LAST = (Y0 + IMG_H <= V_ACTIVE) ? Y0 + IMG_H - 1 : V_ACTIVE - 1;
  localparam logic [15:0] ADDR_LAST = 16'(IMG_W * IMG_H - 1);

  fetch_state_t state_q, state_d;
  logic         in_win, first, hit, border;
  logic [15:0]  addr_d;
  logic [4:0]   pipe_in, pipe_out;
  logic         de_d, hs_d, vs_d, win_d, border_d;

  assign in_win = DE_IN && in_span(int'(X_IN), X0, X_LAST) && in_span(int'(Y_IN), Y0, Y_LAST);
  assign first  = in_win && (int'(X_IN) == X0) && (int'(Y_IN) == Y0);

  // Until the first top-left pixel after reset the window is masked, so a
  // mid-frame reset shows background instead of a torn image.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    addr_d  = ROM_ADDR;
    unique case (state_q)
      WAIT_FRAME: begin
        if (first) begin
          state_d = RUN;
          hit     = 1'b1;
        end
      end
      RUN:     hit = in_win;
      default: state_d = WAIT_FRAME;
    endcase
    if (first)    addr_d = '0;
    else if (hit) addr_d = (ROM_ADDR == ADDR_LAST) ? '0 : ROM_ADDR + 16'd1;
  end

  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      state_q  <= WAIT_FRAME;
      ROM_ADDR <= '0;
    end else begin
      state_q  <= state_d;
      ROM_ADDR <= addr_d;
    end
  end

`ifdef VGA_WINDOW_BORDER_EN
  logic on_vedge, on_hedge;
  always_comb begin
    on_vedge = ((X0 > 0 && int'(X_IN) == X0 - 1) || int'(X_IN) == X0 + IMG_W)
               && in_span(int'(Y_IN), Y0 - 1, Y0 + IMG_H);
    on_hedge = ((Y0 > 0 && int'(Y_IN) == Y0 - 1) || int'(Y_IN) == Y0 + IMG_H)
               && in_span(int'(X_IN), X0 - 1, X0 + IMG_W);
    border   = DE_IN && (state_q == RUN || first) && (on_vedge || on_hedge);
  end
`else
  assign border = 1'b0;
`endif

  assign pipe_in = {border, hit, VSYNC_IN, HSYNC_IN, DE_IN};

  vga_delay_line #(
    .WIDTH(5),
    .DEPTH(L)
  ) u_dly (
    .clk(CLK_40M),
    .rst(RST),
    .d  (pipe_in),
    .q  (pipe_out)
  );

  assign {border_d, win_d, vs_d, hs_d, de_d} = pipe_out;
  assign HSYNC_OUT = hs_d;
  assign VSYNC_OUT = vs_d;
  assign DE_OUT    = de_d;

  // ROM_Q for a pixel lands in its L-th cycle, so selection uses the delayed flags.
  always_comb begin
    DATA_OUT = BLACK;
    if (de_d) begin
      if (border_d)   DATA_OUT = WHITE;
      else if (win_d) DATA_OUT = ROM_Q;
      else            DATA_OUT = BG_COLOR;
    end
  end
endmodule
